// File: rtl/ntt_core_gf64_common_param_pkg.sv
// Shared GF64 NTT parameters: phi twiddle sequencer state encoding and width helpers.
package ntt_core_gf64_common_param_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } phi_twd_seq_state_e;

  function automatic int get_phi_iter_w(input int iter_nb);
    return (iter_nb <= 2) ? 1 : $clog2(iter_nb);
  endfunction

  function automatic int get_phi_lvl_w(input int lvl_nb);
    return (lvl_nb <= 2) ? 1 : $clog2(lvl_nb);
  endfunction

endpackage

// File: rtl/ntt_core_gf64_phi_twd_seq_if.sv
// Stream-in / ROM-read / aligned-valid bundle of the phi twiddle sequencer.
interface ntt_core_gf64_phi_twd_seq_if #(
  parameter int ITER_NB = 128,
  parameter int LVL_NB  = 2
);
  import ntt_core_gf64_common_param_pkg::*;

  localparam int ITER_W = get_phi_iter_w(ITER_NB);
  localparam int LVL_W  = get_phi_lvl_w(LVL_NB);

  logic              in_avail;
  logic              in_sob;
  logic              in_eob;
  logic              rom_ren;
  logic [ITER_W-1:0] rom_add;
  logic              out_avail;
  logic [LVL_W-1:0]  out_lvl;
  logic              error;

  modport master (
    output in_avail, in_sob, in_eob,
    input  rom_ren, rom_add, out_avail, out_lvl, error
  );

  modport slave (
    input  in_avail, in_sob, in_eob,
    output rom_ren, rom_add, out_avail, out_lvl, error
  );

endinterface

// File: rtl/ntt_core_gf64_phi_twd_seq_dly.sv
// Valid + level alignment shift register, covers the phi ROM read latency.
module ntt_core_gf64_phi_twd_seq_dly #(
  parameter int DEPTH = 2,
  parameter int LVL_W = 1
) (
  input  logic             clk,
  input  logic             s_rst,
  input  logic             i_avail,
  input  logic [LVL_W-1:0] i_lvl,
  output logic             o_avail,
  output logic [LVL_W-1:0] o_lvl
);

  if (DEPTH == 0) begin : g_bypass
    assign o_avail = i_avail;
    assign o_lvl   = i_lvl;
  end else begin : g_sr
    logic             r_avail_sr [DEPTH];
    logic [LVL_W-1:0] r_lvl_sr   [DEPTH];

    always_ff @(posedge clk) begin
      if (s_rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_avail_sr[i] <= 1'b0;
          r_lvl_sr[i]   <= '0;
        end
      end else begin
        r_avail_sr[0] <= i_avail;
        r_lvl_sr[0]   <= i_lvl;
        for (int i = 1; i < DEPTH; i++) begin
          r_avail_sr[i] <= r_avail_sr[i-1];
          r_lvl_sr[i]   <= r_lvl_sr[i-1];
        end
      end
    end

    assign o_avail = r_avail_sr[DEPTH-1];
    assign o_lvl   = r_lvl_sr[DEPTH-1];
  end

endmodule

// File: rtl/ntt_core_gf64_phi_twd_seq.sv
// Phi twiddle ROM read sequencer; protocol error flag enabled by NTT_CORE_GF64_PHI_TWD_SEQ_ERR_EN.
// ST_IDLE | waiting for a column flagged sob ; ST_RUN | inside a batch, every column is read
module ntt_core_gf64_phi_twd_seq
  import ntt_core_gf64_common_param_pkg::*;
#(
  parameter int ITER_NB     = 128,
  parameter int LVL_NB      = 2,
  parameter int IN_PIPE     = 1,
  parameter int ROM_LATENCY = 2
) (
  input logic                         clk,
  input logic                         s_rst,
  ntt_core_gf64_phi_twd_seq_if.slave  bus
);

  localparam int ITER_W = get_phi_iter_w(ITER_NB);
  localparam int LVL_W  = get_phi_lvl_w(LVL_NB);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITER_NB - 1);
  localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(LVL_NB - 1);

`ifdef NTT_CORE_GF64_PHI_TWD_SEQ_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic w_avail, w_sob, w_eob;

  if (IN_PIPE != 0) begin : g_in_pipe
    logic r_avail, r_sob, r_eob;
    always_ff @(posedge clk) begin
      if (s_rst) begin
        r_avail <= 1'b0;
        r_sob   <= 1'b0;
        r_eob   <= 1'b0;
      end else begin
        r_avail <= bus.in_avail;
        r_sob   <= bus.in_sob;
        r_eob   <= bus.in_eob;
      end
    end
    assign w_avail = r_avail;
    assign w_sob   = r_sob;
    assign w_eob   = r_eob;
  end else begin : g_in_direct
    assign w_avail = bus.in_avail;
    assign w_sob   = bus.in_sob;
    assign w_eob   = bus.in_eob;
  end

  phi_twd_seq_state_e r_state, w_state_nxt;
  logic [LVL_W-1:0]   r_lvl_cnt, w_lvl_nxt, w_pos_lvl, r_ren_lvl;
  logic [ITER_W-1:0]  r_iter_cnt, w_iter_nxt, w_pos_iter, r_rom_add;
  logic               w_is_last, w_ren, w_err, r_rom_ren, r_error;

  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_state    <= ST_IDLE;
      r_lvl_cnt  <= '0;
      r_iter_cnt <= '0;
      r_rom_ren  <= 1'b0;
      r_rom_add  <= '0;
      r_ren_lvl  <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lvl_cnt  <= w_lvl_nxt;
      r_iter_cnt <= w_iter_nxt;
      r_rom_ren  <= w_ren;
      if (w_ren) begin
        r_rom_add <= w_pos_iter;
        r_ren_lvl <= w_pos_lvl;
      end
      r_error <= r_error | w_err;
    end
  end

  // sob forces the column to position 0, both at batch start and on resync.
  always_comb begin
    w_state_nxt = r_state;
    w_lvl_nxt   = r_lvl_cnt;
    w_iter_nxt  = r_iter_cnt;
    w_ren       = 1'b0;
    w_err       = 1'b0;
    w_pos_lvl   = w_sob ? '0 : r_lvl_cnt;
    w_pos_iter  = w_sob ? '0 : r_iter_cnt;
    w_is_last   = (w_pos_lvl == LVL_LAST) && (w_pos_iter == ITER_LAST);
    if (w_avail) begin
      if ((r_state == ST_IDLE) && !w_sob) begin
        w_err = 1'b1;
      end else begin
        w_ren = 1'b1;
        if ((r_state == ST_RUN) && w_sob) w_err = 1'b1;
        if (w_is_last || w_eob) begin
          if (w_is_last != w_eob) w_err = 1'b1;
          w_state_nxt = ST_IDLE;
          w_lvl_nxt   = '0;
          w_iter_nxt  = '0;
        end else begin
          w_state_nxt = ST_RUN;
          if (w_pos_lvl == LVL_LAST) begin
            w_lvl_nxt  = '0;
            w_iter_nxt = w_pos_iter + 1'b1;
          end else begin
            w_lvl_nxt  = w_pos_lvl + 1'b1;
            w_iter_nxt = w_pos_iter;
          end
        end
      end
    end
  end

  logic             w_out_avail;
  logic [LVL_W-1:0] w_out_lvl;

  ntt_core_gf64_phi_twd_seq_dly #(
    .DEPTH (ROM_LATENCY),
    .LVL_W (LVL_W)
  ) u_dly (
    .clk     (clk),
    .s_rst   (s_rst),
    .i_avail (r_rom_ren),
    .i_lvl   (r_ren_lvl),
    .o_avail (w_out_avail),
    .o_lvl   (w_out_lvl)
  );

  assign bus.rom_ren   = r_rom_ren;
  assign bus.rom_add   = r_rom_add;
  assign bus.out_avail = w_out_avail;
  assign bus.out_lvl   = w_out_lvl;
  assign bus.error     = ERR_EN & r_error;

endmodule

// File: tb/tb_ntt_core_gf64_phi_twd_seq.sv
// Directed bench for the phi twiddle sequencer, ITER_NB=4 LVL_NB=2 IN_PIPE=1 ROM_LATENCY=2.
module tb_ntt_core_gf64_phi_twd_seq;

`ifdef NTT_CORE_GF64_PHI_TWD_SEQ_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic s_rst = 1'b1;
  always #5 clk = ~clk;

  ntt_core_gf64_phi_twd_seq_if #(.ITER_NB(4), .LVL_NB(2)) bus ();

  ntt_core_gf64_phi_twd_seq #(
    .ITER_NB     (4),
    .LVL_NB      (2),
    .IN_PIPE     (1),
    .ROM_LATENCY (2)
  ) dut (
    .clk   (clk),
    .s_rst (s_rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  bit in_av [32], in_sob [32], in_eob [32], in_rst [32];
  int exp_add [32];
  int exp_lvl [32];
  int err_cyc;

  task automatic check_val(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_scn();
    for (int i = 0; i < 32; i++) begin
      in_av[i]   = 1'b0;
      in_sob[i]  = 1'b0;
      in_eob[i]  = 1'b0;
      in_rst[i]  = 1'b0;
      exp_add[i] = -1;
      exp_lvl[i] = -1;
    end
    err_cyc = 1000;
  endtask

  task automatic do_reset(input string name);
    s_rst = 1'b1;
    bus.in_avail = 1'b0;
    bus.in_sob   = 1'b0;
    bus.in_eob   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val({name, "_rst_ren"},   int'(bus.rom_ren),   0);
    check_val({name, "_rst_add"},   int'(bus.rom_add),   0);
    check_val({name, "_rst_avail"}, int'(bus.out_avail), 0);
    check_val({name, "_rst_lvl"},   int'(bus.out_lvl),   0);
    check_val({name, "_rst_err"},   int'(bus.error),     0);
    s_rst = 1'b0;
  endtask

  // Column driven at index c is observed from cycle c+1 onward.
  task automatic run_scn(input string name, input int n);
    int k;
    for (int c = 0; c < n; c++) begin
      s_rst        = in_rst[c];
      bus.in_avail = in_av[c];
      bus.in_sob   = in_sob[c];
      bus.in_eob   = in_eob[c];
      @(posedge clk);
      #1;
      k = c + 1;
      check_val($sformatf("%s_ren@%0d", name, k), int'(bus.rom_ren), (exp_add[k] >= 0) ? 1 : 0);
      if (exp_add[k] >= 0 || in_rst[c])
        check_val($sformatf("%s_add@%0d", name, k), int'(bus.rom_add), in_rst[c] ? 0 : exp_add[k]);
      check_val($sformatf("%s_oav@%0d", name, k), int'(bus.out_avail), (exp_lvl[k] >= 0) ? 1 : 0);
      if (exp_lvl[k] >= 0 || in_rst[c])
        check_val($sformatf("%s_olvl@%0d", name, k), int'(bus.out_lvl), in_rst[c] ? 0 : exp_lvl[k]);
      check_val($sformatf("%s_err@%0d", name, k), int'(bus.error), (ERR_EN && k >= err_cyc) ? 1 : 0);
    end
    s_rst        = 1'b0;
    bus.in_avail = 1'b0;
    bus.in_sob   = 1'b0;
    bus.in_eob   = 1'b0;
  endtask

  initial begin
    // Two nominal batches back to back
    do_reset("nom");
    clear_scn();
    for (int c = 0; c < 16; c++) begin
      in_av[c]       = 1'b1;
      in_sob[c]      = (c % 8) == 0;
      in_eob[c]      = (c % 8) == 7;
      exp_add[c + 2] = (c % 8) / 2;
      exp_lvl[c + 4] = c % 2;
    end
    run_scn("nom", 21);

    do_reset("gap");
    clear_scn();
    for (int j = 0; j < 8; j++) begin
      in_av[2*j]       = 1'b1;
      in_sob[2*j]      = (j == 0);
      in_eob[2*j]      = (j == 7);
      exp_add[2*j + 2] = j / 2;
      exp_lvl[2*j + 4] = j % 2;
    end
    run_scn("gap", 20);

    do_reset("nosob");
    clear_scn();
    for (int c = 0; c < 3; c++) in_av[c] = 1'b1;
    err_cyc = 2;
    run_scn("nosob", 8);

    do_reset("resync");
    clear_scn();
    for (int c = 0; c < 8; c++) begin
      in_av[c]       = 1'b1;
      in_sob[c]      = (c == 0) || (c == 4);
      exp_add[c + 2] = (c % 4) / 2;
      exp_lvl[c + 4] = c % 2;
    end
    err_cyc = 6;
    run_scn("resync", 13);

    do_reset("early");
    clear_scn();
    for (int c = 0; c < 3; c++) begin
      in_av[c]       = 1'b1;
      exp_lvl[c + 4] = c % 2;
    end
    in_sob[0] = 1'b1;
    in_eob[2] = 1'b1;
    exp_add[2] = 0;
    exp_add[3] = 0;
    exp_add[4] = 1;
    for (int c = 4; c < 12; c++) begin
      in_av[c]       = 1'b1;
      in_sob[c]      = (c == 4);
      in_eob[c]      = (c == 11);
      exp_add[c + 2] = (c - 4) / 2;
      exp_lvl[c + 4] = (c - 4) % 2;
    end
    err_cyc = 4;
    run_scn("early", 17);

    do_reset("midrst");
    clear_scn();
    for (int c = 0; c < 3; c++) in_av[c] = 1'b1;
    in_sob[0]  = 1'b1;
    in_rst[3]  = 1'b1;
    exp_add[2] = 0;
    exp_add[3] = 0;
    run_scn("midrst", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
